// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM states,
// stage indices, trap cause codes and mtvec mode encodings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_FENCE_WAIT
    } ctrl_state_e;

    localparam int unsigned STG_F = 0;
    localparam int unsigned STG_D = 1;
    localparam int unsigned STG_E = 2;
    localparam int unsigned STG_M = 3;
    localparam int unsigned STG_W = 4;

    localparam int unsigned CAUSE_LOAD_ACCESS = 5;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/trap_vec_gen.sv
// Trap target address from mtvec; vectored mode offsets interrupts by
// irq_id*4, exceptions and the reserved modes land on the aligned base.
module trap_vec_gen
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] mtvec_i,
    input  logic            is_irq_i,
    input  logic [4:0]      irq_id_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;

    always_comb begin
        base   = {mtvec_i[XLEN-1:2], 2'b00};
        offset = XLEN'({irq_id_i, 2'b00});
        if ((mtvec_i[1:0] == MTVEC_VECTORED) && is_irq_i) begin
            pc_o = base + offset;
        end else begin
            pc_o = base;
        end
    end

endmodule

// File: rtl/pipe_ctrl_v2.sv
// Pipeline controller: arbitrates PC redirect sources and drives per-stage
// stall/flush vectors, load-use interlock, trap entry and fence drain.
module pipe_ctrl_v2
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE  = 5,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CAUSE_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               jump,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    jump_target_addr,
    input  logic [XLEN-1:0]    branch_target_addr,
    input  logic               mret,
    input  logic [XLEN-1:0]    mepc_i,
    input  logic               fence,
    input  logic [XLEN-1:0]    fence_next_pc,
    input  logic [4:0]         rs1_d,
    input  logic [4:0]         rs2_d,
    input  logic [4:0]         rd_e,
    input  logic               mem_read_e,
    input  logic [NSTAGE-1:0]  ext_stall,
    input  logic               lsu_valid,
    input  logic               lsu_err,
    input  logic               lsu_busy,
    input  logic               exc_taken_wb,
    input  logic [CAUSE_W-1:0] exc_cause_wb,
    input  logic [XLEN-1:0]    exc_tval_wb,
    input  logic [XLEN-1:0]    pc_wb,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic               irq_pending,
    input  logic [4:0]         irq_id,
    output logic               set_pc_valid,
    output logic [XLEN-1:0]    set_pc,
    output logic [NSTAGE-1:0]  flush,
    output logic [NSTAGE-1:0]  stall,
    output logic               trap_valid,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic [XLEN-1:0]    trap_tval,
    output logic [XLEN-1:0]    trap_pc,
    output logic               irq_ack,
    output logic               mret_ack,
    output logic               ctrl_busy
);

    ctrl_state_e        state_q, state_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [XLEN-1:0]    tval_q, tval_d;
    logic [XLEN-1:0]    tpc_q, tpc_d;
    logic [XLEN-1:0]    fence_pc_q, fence_pc_d;

    logic               exc;
    logic [CAUSE_W-1:0] exc_cause;
    logic [XLEN-1:0]    exc_tval;
    logic [CAUSE_W-1:0] irq_cause;
    logic               load_use;
    logic [NSTAGE-1:0]  req;
    logic [NSTAGE-1:0]  stall_raw;
    logic [NSTAGE-1:0]  bubble;
    logic [NSTAGE-1:0]  rflush;
    logic [NSTAGE-1:0]  flush_all;
    logic               redir_valid;
    logic [XLEN-1:0]    redir_pc;
    logic               trap_strobe;
    logic               irq_strobe;
    logic               mret_strobe;
    logic [XLEN-1:0]    vec_pc;
    logic               acc;

    trap_vec_gen #(.XLEN(XLEN)) u_vec (
        .mtvec_i  (mtvec_i),
        .is_irq_i (cause_q[CAUSE_W-1]),
        .irq_id_i (cause_q[4:0]),
        .pc_o     (vec_pc)
    );

    always_comb begin
        exc = exc_taken_wb | (lsu_valid & lsu_err);
        if (exc_taken_wb) begin
            exc_cause = exc_cause_wb;
            exc_tval  = exc_tval_wb;
        end else begin
            exc_cause = CAUSE_W'(CAUSE_LOAD_ACCESS);
            exc_tval  = '0;
        end
        irq_cause            = '0;
        irq_cause[4:0]       = irq_id;
        irq_cause[CAUSE_W-1] = 1'b1;
        load_use = mem_read_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
        flush_all = '1;
    end

    // Stall requests cascade downstream-to-upstream; the boundary between a
    // held and a moving stage gets a bubble so nothing is duplicated.
    always_comb begin
        req = ext_stall;
        if ((state_q == ST_IDLE && load_use) || state_q == ST_FENCE_WAIT) begin
            req[STG_F] = 1'b1;
            req[STG_D] = 1'b1;
        end
        acc       = 1'b0;
        stall_raw = '0;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            acc = acc | req[NSTAGE-1-k];
            stall_raw[NSTAGE-1-k] = acc;
        end
        bubble = '0;
        for (int unsigned k = 0; k + 1 < NSTAGE; k++) begin
            bubble[k+1] = stall_raw[k] & ~stall_raw[k+1];
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        tval_d      = tval_q;
        tpc_d       = tpc_q;
        fence_pc_d  = fence_pc_q;
        redir_valid = 1'b0;
        redir_pc    = '0;
        rflush      = '0;
        trap_strobe = 1'b0;
        irq_strobe  = 1'b0;
        mret_strobe = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (exc) begin
                    rflush  = flush_all;
                    cause_d = exc_cause;
                    tval_d  = exc_tval;
                    tpc_d   = pc_wb;
                    state_d = ST_TRAP;
                end else if (irq_pending) begin
                    rflush  = flush_all;
                    cause_d = irq_cause;
                    tval_d  = '0;
                    tpc_d   = pc_wb;
                    state_d = ST_TRAP;
                end else if (!stall_raw[STG_E]) begin
                    // E-stage redirects wait here while E is held; the request stays asserted
                    if (mret) begin
                        redir_valid   = 1'b1;
                        redir_pc      = mepc_i;
                        mret_strobe   = 1'b1;
                        rflush[STG_F] = 1'b1;
                        rflush[STG_D] = 1'b1;
                    end else if (branch_taken) begin
                        redir_valid   = 1'b1;
                        redir_pc      = branch_target_addr;
                        rflush[STG_F] = 1'b1;
                        rflush[STG_D] = 1'b1;
                    end else if (jump) begin
                        redir_valid   = 1'b1;
                        redir_pc      = jump_target_addr;
                        rflush[STG_F] = 1'b1;
                        rflush[STG_D] = 1'b1;
                    end else if (fence) begin
                        rflush[STG_F] = 1'b1;
                        rflush[STG_D] = 1'b1;
                        fence_pc_d    = fence_next_pc;
                        state_d       = ST_FENCE_WAIT;
                    end
                end
            end
            ST_TRAP: begin
                redir_valid   = 1'b1;
                redir_pc      = vec_pc;
                trap_strobe   = 1'b1;
                irq_strobe    = cause_q[CAUSE_W-1];
                rflush[STG_F] = 1'b1;
                state_d       = ST_IDLE;
            end
            ST_FENCE_WAIT: begin
                if (exc) begin
                    rflush  = flush_all;
                    cause_d = exc_cause;
                    tval_d  = exc_tval;
                    tpc_d   = pc_wb;
                    state_d = ST_TRAP;
                end else if (!lsu_busy) begin
                    redir_valid   = 1'b1;
                    redir_pc      = fence_pc_q;
                    rflush[STG_F] = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        set_pc_valid = 1'b0;
        set_pc       = '0;
        flush        = '0;
        stall        = '0;
        trap_valid   = 1'b0;
        irq_ack      = 1'b0;
        mret_ack     = 1'b0;
        if (!reset) begin
            set_pc_valid = redir_valid;
            set_pc       = redir_pc;
            flush        = rflush | bubble;
            stall        = stall_raw & ~(rflush | bubble);
            trap_valid   = trap_strobe;
            irq_ack      = irq_strobe;
            mret_ack     = mret_strobe;
        end
        ctrl_busy  = (state_q != ST_IDLE);
        trap_cause = cause_q;
        trap_tval  = tval_q;
        trap_pc    = tpc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cause_q    <= '0;
            tval_q     <= '0;
            tpc_q      <= '0;
            fence_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            tval_q     <= tval_d;
            tpc_q      <= tpc_d;
            fence_pc_q <= fence_pc_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Directed bench for pipe_ctrl_v2 with hand-computed expected values.
module tb_pipe_ctrl_v2;

    logic        clk = 1'b0;
    logic        reset;
    logic        jump, branch_taken;
    logic [31:0] jump_target_addr, branch_target_addr;
    logic        mret;
    logic [31:0] mepc_i;
    logic        fence;
    logic [31:0] fence_next_pc;
    logic [4:0]  rs1_d, rs2_d, rd_e;
    logic        mem_read_e;
    logic [4:0]  ext_stall;
    logic        lsu_valid, lsu_err, lsu_busy;
    logic        exc_taken_wb;
    logic [5:0]  exc_cause_wb;
    logic [31:0] exc_tval_wb, pc_wb, mtvec_i;
    logic        irq_pending;
    logic [4:0]  irq_id;
    logic        set_pc_valid;
    logic [31:0] set_pc;
    logic [4:0]  flush, stall;
    logic        trap_valid;
    logic [5:0]  trap_cause;
    logic [31:0] trap_tval, trap_pc;
    logic        irq_ack, mret_ack, ctrl_busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl_v2 #(.NSTAGE(5), .XLEN(32), .CAUSE_W(6)) dut (
        .clk(clk), .reset(reset),
        .jump(jump), .branch_taken(branch_taken),
        .jump_target_addr(jump_target_addr), .branch_target_addr(branch_target_addr),
        .mret(mret), .mepc_i(mepc_i),
        .fence(fence), .fence_next_pc(fence_next_pc),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e), .mem_read_e(mem_read_e),
        .ext_stall(ext_stall),
        .lsu_valid(lsu_valid), .lsu_err(lsu_err), .lsu_busy(lsu_busy),
        .exc_taken_wb(exc_taken_wb), .exc_cause_wb(exc_cause_wb),
        .exc_tval_wb(exc_tval_wb), .pc_wb(pc_wb),
        .mtvec_i(mtvec_i), .irq_pending(irq_pending), .irq_id(irq_id),
        .set_pc_valid(set_pc_valid), .set_pc(set_pc),
        .flush(flush), .stall(stall),
        .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .trap_pc(trap_pc),
        .irq_ack(irq_ack), .mret_ack(mret_ack), .ctrl_busy(ctrl_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quiet();
        jump = 0; branch_taken = 0; jump_target_addr = '0; branch_target_addr = '0;
        mret = 0; mepc_i = '0; fence = 0; fence_next_pc = '0;
        rs1_d = '0; rs2_d = '0; rd_e = '0; mem_read_e = 0; ext_stall = '0;
        lsu_valid = 0; lsu_err = 0; lsu_busy = 0;
        exc_taken_wb = 0; exc_cause_wb = '0; exc_tval_wb = '0; pc_wb = '0;
        irq_pending = 0; irq_id = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        quiet();
        mtvec_i = '0;
        reset   = 1;
        next_cycle();
        next_cycle();
        chk("rst_busy", ctrl_busy, 0);
        chk("rst_flush", flush, 0);
        chk("rst_spv", set_pc_valid, 0);
        chk("rst_cause", trap_cause, 0);
        reset = 0;
        #1;
        chk("idle_stall", stall, 0);

        // branch redirect
        branch_taken = 1; branch_target_addr = 32'h100; #1;
        chk("br_spv", set_pc_valid, 1);
        chk("br_pc", set_pc, 32'h100);
        chk("br_flush", flush, 5'b00011);
        chk("br_stall", stall, 0);
        // branch beats jump
        jump = 1; jump_target_addr = 32'h340; #1;
        chk("brjmp_pc", set_pc, 32'h100);
        next_cycle(); quiet();
        jump = 1; jump_target_addr = 32'h340; #1;
        chk("jmp_pc", set_pc, 32'h340);
        next_cycle(); quiet();
        mret = 1; mepc_i = 32'h1234; #1;
        chk("mret_pc", set_pc, 32'h1234);
        chk("mret_ack", mret_ack, 1);
        next_cycle(); quiet();

        // load-use
        mem_read_e = 1; rd_e = 5; rs1_d = 3; rs2_d = 5; #1;
        chk("lu_stall", stall, 5'b00011);
        chk("lu_flush", flush, 5'b00100);
        rd_e = 0; rs1_d = 0; rs2_d = 0; #1;
        chk("lu_x0_stall", stall, 0);
        chk("lu_x0_flush", flush, 0);
        next_cycle(); quiet();

        // vectored interrupt
        mtvec_i = 32'h8000_0001; irq_pending = 1; irq_id = 7; pc_wb = 32'h400; #1;
        chk("irq_flush", flush, 5'b11111);
        chk("irq_stall", stall, 0);
        chk("irq_n_spv", set_pc_valid, 0);
        next_cycle(); quiet();
        chk("irq_busy", ctrl_busy, 1);
        chk("irq_spv", set_pc_valid, 1);
        chk("irq_vec", set_pc, 32'h8000_001C);
        chk("irq_cause", trap_cause, 6'h27);
        chk("irq_tval", trap_tval, 0);
        chk("irq_tpc", trap_pc, 32'h400);
        chk("irq_ack", irq_ack, 1);
        chk("irq_tv", trap_valid, 1);
        chk("irq_f0", flush, 5'b00001);
        next_cycle();
        chk("irq_done_busy", ctrl_busy, 0);
        chk("irq_done_ack", irq_ack, 0);

        // exception beats jump; vectored mode exception uses base
        exc_taken_wb = 1; exc_cause_wb = 2; exc_tval_wb = 32'hDEAD; pc_wb = 32'h500;
        jump = 1; jump_target_addr = 32'h999; #1;
        chk("exc_flush", flush, 5'b11111);
        chk("exc_nojmp", set_pc_valid, 0);
        next_cycle(); quiet();
        chk("exc_vec", set_pc, 32'h8000_0000);
        chk("exc_cause", trap_cause, 2);
        chk("exc_tval", trap_tval, 32'hDEAD);
        chk("exc_tpc", trap_pc, 32'h500);
        chk("exc_noack", irq_ack, 0);
        next_cycle();

        // LSU error, reserved mode 3 acts as direct
        mtvec_i = 32'h0000_0103; lsu_valid = 1; lsu_err = 1; pc_wb = 32'h600; #1;
        next_cycle(); quiet();
        chk("lsu_vec", set_pc, 32'h100);
        chk("lsu_cause", trap_cause, 5);
        chk("lsu_tval", trap_tval, 0);
        next_cycle();

        // fence drain
        fence = 1; fence_next_pc = 32'h204; lsu_busy = 1; #1;
        chk("fe_flush", flush, 5'b00011);
        chk("fe_spv", set_pc_valid, 0);
        next_cycle(); fence = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fw_busy", ctrl_busy, 1);
            chk("fw_stall", stall, 5'b00011);
            chk("fw_flush", flush, 5'b00100);
            chk("fw_spv", set_pc_valid, 0);
            next_cycle();
        end
        lsu_busy = 0; #1;
        chk("fw_rd_spv", set_pc_valid, 1);
        chk("fw_rd_pc", set_pc, 32'h204);
        chk("fw_rd_flush", flush, 5'b00101);
        chk("fw_rd_stall", stall, 5'b00010);
        next_cycle(); quiet();
        chk("fw_exit_busy", ctrl_busy, 0);

        // exception preempts fence
        mtvec_i = 32'h200; fence = 1; fence_next_pc = 32'h300; lsu_busy = 1; #1;
        next_cycle(); quiet(); lsu_busy = 1;
        exc_taken_wb = 1; exc_cause_wb = 7; #1;
        chk("fwx_flush", flush, 5'b11111);
        next_cycle(); quiet();
        chk("fwx_vec", set_pc, 32'h200);
        chk("fwx_cause", trap_cause, 7);
        next_cycle();
        chk("fwx_busy", ctrl_busy, 0);

        // external stall
        ext_stall = 5'b01000; #1;
        chk("es_stall", stall, 5'b01111);
        chk("es_flush", flush, 5'b10000);
        ext_stall = 5'b00100; branch_taken = 1; branch_target_addr = 32'h700; #1;
        chk("es_held_spv", set_pc_valid, 0);
        chk("es_held_stall", stall, 5'b00111);
        chk("es_held_flush", flush, 5'b01000);
        ext_stall = '0; #1;
        chk("es_rel_spv", set_pc_valid, 1);
        chk("es_rel_pc", set_pc, 32'h700);
        next_cycle(); quiet();

        // reset during TRAP
        irq_pending = 1; irq_id = 3; pc_wb = 32'h800; #1;
        next_cycle(); quiet();
        chk("rt_in_trap", ctrl_busy, 1);
        reset = 1;
        next_cycle();
        reset = 0; #1;
        chk("rt_busy", ctrl_busy, 0);
        chk("rt_spv", set_pc_valid, 0);
        chk("rt_tv", trap_valid, 0);
        chk("rt_ack", irq_ack, 0);
        chk("rt_cause", trap_cause, 0);
        chk("rt_tpc", trap_pc, 0);
        chk("rt_flush", flush, 0);
        chk("rt_stall", stall, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
